// File: rtl/round_robin_mux_arbiter.sv
// Four-way round-robin arbiter driving the select lines of a shared 4:1 mux.
// A contended grant is held at most MAX_HOLD cycles before rotating onward.
module round_robin_mux_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       address0,
   output logic       address1,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [2:0] HMAX = 3'(MAX_HOLD - 1);

   state_t     state, nxt_state;
   logic [1:0] ptr, nxt_ptr;
   logic [1:0] idx, nxt_idx;
   logic [2:0] hcnt, nxt_hcnt;
   logic [3:0] nxt_grant;
   logic       nxt_busy;
   logic [3:0] others;
   logic [1:0] g1;
   logic [2:0] pick_p, pick_g;

   // {found, index} of the first set bit of r, scanning s, s+1, s+2, s+3 mod 4
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] s);
      logic [2:0] res;
      logic [1:0] i;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         i = s + 2'(k);
         if (r[i]) res = {1'b1, i};
      end
      return res;
   endfunction

   // idx is the current grantee while in GRANT and the last grantee in IDLE
   assign others = req & ~(4'b0001 << idx);
   assign g1     = idx + 2'd1;
   assign pick_p = rr_pick(req, ptr);
   assign pick_g = rr_pick(others, g1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= 2'd0;
         idx   <= 2'd0;
         hcnt  <= 3'd0;
         grant <= 4'b0000;
         busy  <= 1'b0;
      end else begin
         state <= nxt_state;
         ptr   <= nxt_ptr;
         idx   <= nxt_idx;
         hcnt  <= nxt_hcnt;
         grant <= nxt_grant;
         busy  <= nxt_busy;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_ptr   = ptr;
      nxt_idx   = idx;
      nxt_hcnt  = hcnt;
      case (state)
         IDLE: begin
            if (pick_p[2]) begin
               nxt_state = GRANT;
               nxt_idx   = pick_p[1:0];
               nxt_hcnt  = 3'd0;
            end
         end
         GRANT: begin
            if (!req[idx]) begin
               nxt_ptr  = g1;
               nxt_hcnt = 3'd0;
               if (pick_g[2]) nxt_idx = pick_g[1:0];
               else           nxt_state = IDLE;
            end else if (!pick_g[2]) begin
               if (hcnt != HMAX) nxt_hcnt = hcnt + 3'd1;
            end else if (hcnt < HMAX) begin
               nxt_hcnt = hcnt + 3'd1;
            end else begin
               nxt_idx  = pick_g[1:0];
               nxt_ptr  = g1;
               nxt_hcnt = 3'd0;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      nxt_grant = 4'b0000;
      nxt_busy  = 1'b0;
      if (nxt_state == GRANT) begin
         nxt_grant = 4'b0001 << nxt_idx;
         nxt_busy  = 1'b1;
      end
   end

   assign address1 = idx[1];
   assign address0 = idx[0];

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Directed bench for round_robin_mux_arbiter (MAX_HOLD = 4) with per-cycle
// invariant checks on grant/busy/address.
module tb_round_robin_mux_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant;
   logic       address0, address1, busy;
   int         tests = 0;
   int         fails = 0;
   bit         inv_on = 1'b0;

   round_robin_mux_arbiter #(.MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant),
      .address0(address0), .address1(address1), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Invariants sampled on the falling edge, away from state updates
   always @(negedge clk) begin
      if (inv_on && !reset) begin
         tests++;
         assert ($onehot0(grant) && (busy === |grant)) else begin
            fails++;
            $error("FAIL inv_onehot_busy: observed grant=%b busy=%b expected onehot0 grant with busy=OR", grant, busy);
         end
         if (grant != 4'b0000) begin
            tests++;
            assert ({address1, address0} === enc(grant)) else begin
               fails++;
               $error("FAIL inv_address: observed %0d expected %0d", {address1, address0}, enc(grant));
            end
         end
      end
   end

   initial begin
      // reset state
      #1 reset = 1'b1;
      #1;
      inv_on = 1'b1;
      chk("rst_grant", 8'(grant), 8'h0);
      chk("rst_busy",  8'(busy), 8'h0);
      chk("rst_addr",  8'({address1, address0}), 8'h0);
      chk("rst_ptr",   8'(dut.ptr), 8'h0);
      chk("rst_hcnt",  8'(dut.hcnt), 8'h0);
      step();
      chk("rst_hold_grant", 8'(grant), 8'h0);
      #2 reset = 1'b0;

      // single requester 2, then release
      req = 4'b0100;
      step();
      chk("r2_grant", 8'(grant), 8'h4);
      chk("r2_addr",  8'({address1, address0}), 8'h2);
      chk("r2_busy",  8'(busy), 8'h1);
      req = 4'b0000;
      step();
      chk("rel_grant", 8'(grant), 8'h0);
      chk("rel_busy",  8'(busy), 8'h0);
      chk("rel_addr",  8'({address1, address0}), 8'h2);
      step();
      chk("idle_grant", 8'(grant), 8'h0);
      chk("idle_addr",  8'({address1, address0}), 8'h2);

      // reset between edges so ptr = 0, then full contention
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         step();
         chk($sformatf("rot_%0d", k), 8'(grant), 8'(4'b0001 << ((k / 4) % 4)));
      end

      // handoff without a bubble: 0001 -> 0010 -> 1000
      req = 4'b0010;
      step();
      chk("hand_0010", 8'(grant), 8'h2);
      req = 4'b1001;
      step();
      chk("hand_1000", 8'(grant), 8'h8);
      chk("hand_busy", 8'(busy), 8'h1);
      chk("hand_ptr",  8'(dut.ptr), 8'h2);
      chk("hand_addr", 8'({address1, address0}), 8'h3);

      // sole requester holds, hcnt saturates, then forced rotation
      req = 4'b0001;
      step();
      chk("sole_first", 8'(grant), 8'h1);
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("sole_%0d", k), 8'(grant), 8'h1);
      end
      chk("sole_hcnt", 8'(dut.hcnt), 8'h3);
      req = 4'b0101;
      step();
      chk("force_0100", 8'(grant), 8'h4);
      chk("force_hcnt", 8'(dut.hcnt), 8'h0);
      // contended hold lasts MAX_HOLD cycles, then wraps forward to 0
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("hold2_%0d", k), 8'(grant), 8'h4);
      end
      step();
      chk("wrap_0001", 8'(grant), 8'h1);

      // move to requester 3, glitch on req between edges is ignored
      req = 4'b1000;
      step();
      chk("g3_grant", 8'(grant), 8'h8);
      req = 4'b0000;
      #2 req = 4'b1000;
      step();
      chk("glitch_grant", 8'(grant), 8'h8);

      // asynchronous reset mid-grant
      #2 reset = 1'b1;
      #1;
      chk("arst_grant", 8'(grant), 8'h0);
      chk("arst_busy",  8'(busy), 8'h0);
      chk("arst_addr",  8'({address1, address0}), 8'h0);
      step();
      chk("arst_hold", 8'(grant), 8'h0);
      #2 reset = 1'b0;
      step();
      chk("post_grant", 8'(grant), 8'h8);
      chk("post_addr",  8'({address1, address0}), 8'h3);
      chk("post_busy",  8'(busy), 8'h1);

      req = 4'b0000;
      step();
      chk("final_idle", 8'(grant), 8'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
